// File: rtl/vx_tensor_wb_serializer.sv
// Two-entry tile buffer between the tensor DPU and register-file writeback.
// Each buffered 4x4 fp32 tile is streamed out one row per valid/ready beat.
module vx_tensor_wb_serializer #(
  parameter int unsigned TAG_WIDTH = 8,
  parameter int unsigned DEPTH     = 2
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        valid_in,
  input  logic [3:0][3:0][31:0]       D_tile,
  input  logic [TAG_WIDTH-1:0]        tag_in,
  output logic                        stall,
  output logic                        wb_valid,
  input  logic                        wb_ready,
  output logic [3:0][31:0]            wb_data,
  output logic [1:0]                  wb_row,
  output logic [TAG_WIDTH-1:0]        wb_tag,
  output logic                        wb_last
);

  localparam int unsigned ROWS    = 4;
  localparam int unsigned COLS    = 4;
  localparam int unsigned WORD_W  = 32;
  localparam int unsigned CNT_W   = 2;
  localparam int unsigned ROW_W   = 2;
  localparam logic [CNT_W-1:0] FULL     = CNT_W'(2);
  localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(ROWS - 1);

  typedef logic [ROWS-1:0][COLS-1:0][WORD_W-1:0] tile_t;

  if (DEPTH != 2) begin : g_depth_check
    $error("vx_tensor_wb_serializer: only DEPTH == 2 is supported");
  end

  logic [CNT_W-1:0]     count_q, count_d;
  logic                 wr_ptr_q, wr_ptr_d;
  logic                 rd_ptr_q, rd_ptr_d;
  logic [ROW_W-1:0]     row_q, row_d;
  tile_t                tile_mem_q [2];
  logic [TAG_WIDTH-1:0] tag_mem_q  [2];

  logic push_c;
  logic fire_c;
  logic pop_c;

  // stall depends only on registered occupancy, never on valid_in/wb_ready
  assign stall    = (count_q == FULL);
  assign wb_valid = (count_q != CNT_W'(0));
  assign wb_data  = tile_mem_q[rd_ptr_q][row_q];
  assign wb_tag   = tag_mem_q[rd_ptr_q];
  assign wb_row   = row_q;
  assign wb_last  = (row_q == LAST_ROW);

  assign push_c = valid_in && !stall;
  assign fire_c = wb_valid && wb_ready;
  assign pop_c  = fire_c && (row_q == LAST_ROW);

  // Next-state for pointers, row counter and occupancy
  always_comb begin
    count_d  = count_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    row_d    = row_q;
    if (push_c) begin
      wr_ptr_d = ~wr_ptr_q;
    end
    if (fire_c) begin
      row_d = row_q + ROW_W'(1);
    end
    if (pop_c) begin
      rd_ptr_d = ~rd_ptr_q;
    end
    case ({push_c, pop_c})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q  <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      row_q    <= '0;
    end else begin
      count_q  <= count_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      row_q    <= row_d;
    end
  end

  // Payload storage carries no reset; occupancy alone decides validity
  always_ff @(posedge clk) begin
    if (push_c) begin
      tile_mem_q[wr_ptr_q] <= D_tile;
      tag_mem_q[wr_ptr_q]  <= tag_in;
    end
  end

endmodule

// File: doc/vx_tensor_wb_serializer.md
# vx_tensor_wb_serializer

Writeback serializer directly downstream of the tensor dot-product unit (`VX_tensor_dpu`). It captures each completed 4x4 fp32 D tile, buffers up to two tiles, and streams each tile to the register-file writeback path one row (4 x 32 bits) per beat under a valid/ready handshake. It backpressures the DPU through the DPU's `stall` input.

## Interface
- `TAG_WIDTH`, default 8: width of the writeback tag (warp id / destination register) carried with each tile.
- `DEPTH`, default 2: tile buffer entries. Only 2 is supported; a parameter check fails elaboration otherwise.

Ports:
- `clk`, input, 1: clock. This is the single clock of the block.
- `reset`, input, 1: asynchronous, active-high reset.
- `valid_in`, input, 1: DPU `valid_out`. A D tile and its tag are present.
- `D_tile`, input, [3:0][3:0][31:0]: result tile, indexed `D_tile[row][col]`.
- `tag_in`, input, TAG_WIDTH: tag accompanying `D_tile`.
- `stall`, output, 1: drives DPU `stall`. High means the tile is not accepted.
- `wb_valid`, output, 1: a row beat is presented.
- `wb_ready`, input, 1: writeback accepts the beat.
- `wb_data`, output, [3:0][31:0]: row data, `wb_data[col] = D_tile[wb_row][col]`.
- `wb_row`, output, 2: row index of the current beat.
- `wb_tag`, output, TAG_WIDTH: tag of the tile being drained.
- `wb_last`, output, 1: high on the row-3 beat.

## Operation
- Tile FIFO: 2 entries of {tile, tag}, with 1-bit `wr_ptr` and `rd_ptr` and a 2-bit `count` (range 0..2).
- `stall = (count == 2)`. It is a pure function of registered state and has no combinational path from `valid_in` or `wb_ready`.
- Push: `valid_in && !stall`. The tile and tag are written at `wr_ptr`, then `wr_ptr` toggles.
- Row counter `row_q` (range 0..3) indexes the head entry.
- Beat fires on `wb_valid && wb_ready`. When a beat fires, `row_q` increments.
- On the beat where `row_q == 3`, `row_q` wraps to 0, the head is popped, and `rd_ptr` toggles.
- Output signals:
  - `wb_valid = (count != 0)`.
  - `wb_data` and `wb_tag` come from the head entry.
  - `wb_row = row_q`.
  - `wb_last = (row_q == 3)`.
- Rows are always emitted in order 0,1,2,3. Tiles are emitted in acceptance order. A tile is fully drained before any row of the next tile.
- Count update:
  - Push only: +1.
  - Pop only: -1.
  - Push and pop in the same cycle: unchanged. This is legal only when `count == 1`, because `stall` blocks a push when `count == 2`, even if that cycle pops.
- No bypass: a tile pushed into an empty FIFO is first visible on the cycle after the push.
- Holding rule: while `wb_valid && !wb_ready`, all of `wb_data`, `wb_row`, `wb_tag` and `wb_last` are held stable.
- Reset: `count`, `wr_ptr`, `rd_ptr` and `row_q` all go to 0.
  - Reset mid-drain discards all buffered tiles and any partial tile.
  - FIFO storage is not reset.

## Timing
- Reset values:
  - `stall = 0`, `wb_valid = 0`, `wb_row = 0`, `wb_last = 0`.
  - `wb_data` and `wb_tag` are don't-care while `wb_valid = 0`.
- Latency: a push at edge N gives `wb_valid = 1` with row 0 in cycle N+1.
- Throughput with `wb_ready` held high: 4 beats per tile, back-to-back across tiles with no bubble.
- `stall` rises in the cycle after the push that fills the FIFO to 2. It falls in the cycle after the pop on the last row.
- With `wb_ready` constantly high and the DPU producing one tile every cycle, the sustained acceptance rate is 1 tile per 4 cycles.
- While `stall` is high, the DPU holds `valid_in`, `D_tile` and `tag_in`. The block samples them when `stall` falls.
- `wb_ready` may toggle arbitrarily. The beat advances only on the handshake.

## Test plan
- Single tile with `D_tile[r][c] = 16*r + c`, tag 0x5A, `wb_ready = 1`:
  - First beat is the cycle after the push.
  - Beats are rows 0..3 with `wb_data = {16r+3, 16r+2, 16r+1, 16r}`.
  - `wb_tag` is 0x5A on every beat; `wb_last` is high only on row 3.
  - Then `wb_valid = 0`.
- Three tiles offered on consecutive cycles, `wb_ready = 1`:
  - Tiles 0 and 1 are accepted; `stall` is high for tile 2.
  - Tile 2 is accepted in the cycle after tile 0's row-3 pop.
  - 12 beats emerge in order with no bubbles.
- `wb_ready` random at 30% duty:
  - Outputs are stable while waiting.
  - All 16 words of each of 8 tiles match the scoreboard.
  - `stall` never high while `count < 2`.
- Push in the same cycle as the last-row pop with `count = 1`: `count` stays 1, and the next beat is row 0 of the new tile with its tag.
- Assert `reset` asynchronously mid-drain at row 2 with 2 tiles buffered:
  - `wb_valid`, `stall` and `wb_row` go to 0 immediately, without waiting for a clock edge.
  - After release, a new tile drains starting at row 0.
- `wb_ready = 0` for 20 cycles with 2 tiles buffered:
  - `stall` is held at 1.
  - `wb_row` stays 0 with row-0 data held.
  - No DPU tile is lost: the held tile is accepted later.
